// File: rtl/mccu_pkg.sv
// Shared constants for the multi-cycle control unit: ISA codes, state encoding,
// ALU operation codes and datapath select values.
package mccu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    // Same ALU op encoding as the single-cycle control unit
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    typedef struct packed {
        logic rtype;
        logic shift;
        logic imm;
        logic sext;
        logic load;
        logic store;
        logic branch;
        logic bne;
        logic jump;
        logic jal;
        logic jr;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction classifier: op/func to instruction class flags
// and the ALU operation used while the instruction executes.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output iclass_t    o_cls,
    output logic [3:0] o_aluc
);

    always_comb begin
        o_cls  = '0;
        o_aluc = ALUC_ADD;
        case (i_op)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADD: o_cls.rtype = 1'b1;
                    FN_SUB: begin o_cls.rtype = 1'b1; o_aluc = ALUC_SUB; end
                    FN_AND: begin o_cls.rtype = 1'b1; o_aluc = ALUC_AND; end
                    FN_OR:  begin o_cls.rtype = 1'b1; o_aluc = ALUC_OR;  end
                    FN_XOR: begin o_cls.rtype = 1'b1; o_aluc = ALUC_XOR; end
                    FN_SLL: begin o_cls.rtype = 1'b1; o_cls.shift = 1'b1; o_aluc = ALUC_SLL; end
                    FN_SRL: begin o_cls.rtype = 1'b1; o_cls.shift = 1'b1; o_aluc = ALUC_SRL; end
                    FN_SRA: begin o_cls.rtype = 1'b1; o_cls.shift = 1'b1; o_aluc = ALUC_SRA; end
                    FN_JR:  begin o_cls.jump  = 1'b1; o_cls.jr = 1'b1; end
                    default: o_cls.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin o_cls.imm = 1'b1; o_cls.sext = 1'b1; end
            OP_ANDI: begin o_cls.imm = 1'b1; o_aluc = ALUC_AND; end
            OP_ORI:  begin o_cls.imm = 1'b1; o_aluc = ALUC_OR;  end
            OP_XORI: begin o_cls.imm = 1'b1; o_aluc = ALUC_XOR; end
            OP_LUI:  begin o_cls.imm = 1'b1; o_aluc = ALUC_LUI; end
            OP_LW:   begin o_cls.load  = 1'b1; o_cls.sext = 1'b1; end
            OP_SW:   begin o_cls.store = 1'b1; o_cls.sext = 1'b1; end
            OP_BEQ:  begin o_cls.branch = 1'b1; o_aluc = ALUC_SUB; end
            OP_BNE:  begin o_cls.branch = 1'b1; o_cls.bne = 1'b1; o_aluc = ALUC_SUB; end
            OP_J:    o_cls.jump = 1'b1;
            OP_JAL:  begin o_cls.jump = 1'b1; o_cls.jal = 1'b1; end
            default: o_cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mccontrolunit_fsm.sv
// Multi-cycle MIPS-subset control unit (IF/ID/EXE/MEM/WB) with ready-stalled memory.
// Define MCCU_PERF_EN to add the instret/stallcnt performance counters.
module mccontrolunit_fsm
    import mccu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
)(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       wir,
    output logic       wpc,
    output logic       wmem,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsrc,
    output logic [2:0] state,
    output logic       illegal,
    output logic       buserr
`ifdef MCCU_PERF_EN
    ,
    output logic [31:0] instret,
    output logic [31:0] stallcnt
`endif
);

    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam int CNT_W   = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

    state_t           r_state, w_next;
    iclass_t          w_cls;
    logic [3:0]       w_aluc;
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_buserr;
    logic             w_stall, w_timeout;
    logic             w_mem_req, w_wir, w_wpc, w_wmem, w_wreg;

    mccu_decode u_decode (
        .i_op   (op),
        .i_func (func),
        .o_cls  (w_cls),
        .o_aluc (w_aluc)
    );

    assign w_stall   = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;
    // mem_ready wins on the last allowed cycle because w_stall is already false then
    assign w_timeout = (MEM_TIMEOUT > 0) && w_stall && (r_to_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= S_IF;
            r_buserr <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_timeout)
                r_buserr <= 1'b1;
            if (w_stall && !w_timeout && (MEM_TIMEOUT > 0))
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_wir     = 1'b0;
        w_wpc     = 1'b0;
        w_wmem    = 1'b0;
        w_wreg    = 1'b0;
        iord      = 1'b0;
        regrt     = 1'b0;
        m2reg     = 1'b0;
        jal       = 1'b0;
        sext      = 1'b0;
        shift     = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_RT;
        aluc      = ALUC_ADD;
        pcsrc     = PC_ALU;
        illegal   = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_req = 1'b1;
                alusrcb   = SRCB_FOUR;
                if (mem_ready) begin
                    w_wir  = 1'b1;
                    w_wpc  = 1'b1;
                    w_next = S_ID;
                end
            end
            S_ID: begin
                alusrcb = SRCB_BR;
                sext    = 1'b1;
                if (w_cls.illegal) begin
                    illegal = 1'b1;
                    w_next  = S_IF;
                end else if (w_cls.jump) begin
                    w_wpc  = 1'b1;
                    pcsrc  = w_cls.jr ? PC_RS : PC_JMP;
                    w_wreg = w_cls.jal;
                    jal    = w_cls.jal;
                    w_next = S_IF;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE, S_WB: begin
                // WB keeps the EXE ALU setup so the result stays stable while it is written
                alusrca = 1'b1;
                aluc    = w_aluc;
                if (w_cls.rtype || w_cls.branch) begin
                    shift = w_cls.shift;
                end else begin
                    alusrcb = SRCB_IMM;
                    sext    = w_cls.sext;
                end
                if (r_state == S_WB) begin
                    w_wreg = 1'b1;
                    regrt  = w_cls.imm || w_cls.load;
                    m2reg  = w_cls.load;
                    w_next = S_IF;
                end else if (w_cls.branch) begin
                    if (w_cls.bne ? !z : z) begin
                        w_wpc = 1'b1;
                        pcsrc = PC_BR;
                    end
                    w_next = S_IF;
                end else if (w_cls.load || w_cls.store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                w_wmem    = w_cls.store && !w_timeout;
                if (mem_ready)
                    w_next = w_cls.load ? S_WB : S_IF;
                else if (w_timeout)
                    w_next = S_IF;
            end
            default: w_next = S_IF;
        endcase
    end

    // Reset forces every strobe low even though the reset state is IF
    assign mem_req = w_mem_req & clrn;
    assign wir     = w_wir     & clrn;
    assign wpc     = w_wpc     & clrn;
    assign wmem    = w_wmem    & clrn;
    assign wreg    = w_wreg    & clrn;
    assign state   = r_state;
    assign buserr  = r_buserr;

`ifdef MCCU_PERF_EN
    logic [31:0] r_instret, r_stallcnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_instret  <= '0;
            r_stallcnt <= '0;
        end else begin
            if ((r_state != S_IF) && (w_next == S_IF))
                r_instret <= r_instret + 32'd1;
            if (w_stall)
                r_stallcnt <= r_stallcnt + 32'd1;
        end
    end

    assign instret  = r_instret;
    assign stallcnt = r_stallcnt;
`endif

endmodule

// File: tb/tb_mccontrolunit_fsm.sv
// Scoreboard bench for mccontrolunit_fsm: stimulus queues per-cycle expected control
// vectors, a monitor compares them against the DUT outputs on the falling edge.
module tb_mccontrolunit_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal, sext, shift, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
        logic [1:0] pcsrc;
        logic       illegal, buserr;
    } obs_t;

    localparam logic [5:0] R = 6'b000000;
    localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0100, A_OR = 4'b0101,
                           A_LUI = 4'b0110, A_SRA = 4'b1111;

    logic       clk = 1'b0;
    logic       clrn;
    logic [5:0] op, func;
    logic       z, mem_ready;
    logic       mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluc;
    logic [2:0] state;
    logic       illegal, buserr;
`ifdef MCCU_PERF_EN
    logic [31:0] instret, stallcnt;
`endif

    int    n_chk = 0;
    int    n_err = 0;
    obs_t  q_exp[$];
    string q_name[$];

    mccontrolunit_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .wir(wir), .wpc(wpc), .wmem(wmem), .wreg(wreg),
        .regrt(regrt), .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc),
        .state(state), .illegal(illegal), .buserr(buserr)
`ifdef MCCU_PERF_EN
        , .instret(instret), .stallcnt(stallcnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic obs_t e_rst();
        obs_t e = '0;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    function automatic obs_t e_if(logic rdy, logic be);
        obs_t e = '0;
        e.mem_req = 1'b1; e.alusrcb = 2'b01; e.wir = rdy; e.wpc = rdy; e.buserr = be;
        return e;
    endfunction

    function automatic obs_t e_id(logic be);
        obs_t e = '0;
        e.st = 3'd1; e.alusrcb = 2'b11; e.sext = 1'b1; e.buserr = be;
        return e;
    endfunction

    function automatic obs_t e_jmp(logic [1:0] ps, logic jl);
        obs_t e = e_id(1'b0);
        e.wpc = 1'b1; e.pcsrc = ps; e.wreg = jl; e.jal = jl;
        return e;
    endfunction

    function automatic obs_t e_ill();
        obs_t e = e_id(1'b0);
        e.illegal = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_alu(logic [2:0] st, logic [1:0] srcb, logic [3:0] ac, logic sx, logic sh);
        obs_t e = '0;
        e.st = st; e.alusrca = 1'b1; e.alusrcb = srcb; e.aluc = ac; e.sext = sx; e.shift = sh;
        return e;
    endfunction

    function automatic obs_t e_wb(logic [1:0] srcb, logic [3:0] ac, logic sx, logic sh, logic rt, logic m2);
        obs_t e = e_alu(3'd4, srcb, ac, sx, sh);
        e.wreg = 1'b1; e.regrt = rt; e.m2reg = m2;
        return e;
    endfunction

    function automatic obs_t e_br(logic taken);
        obs_t e = e_alu(3'd2, 2'b00, A_SUB, 1'b0, 1'b0);
        e.wpc = taken; e.pcsrc = taken ? 2'b01 : 2'b00;
        return e;
    endfunction

    function automatic obs_t e_mem(logic wm, logic be);
        obs_t e = '0;
        e.st = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.wmem = wm; e.buserr = be;
        return e;
    endfunction

    // One clock cycle: drive inputs, queue what the DUT must show during this cycle
    task automatic cyc(string nm, logic [5:0] o, logic [5:0] f, logic zz, logic rdy, obs_t e);
        op = o; func = f; z = zz; mem_ready = rdy;
        q_exp.push_back(e);
        q_name.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic if_id(string nm, logic [5:0] o, logic [5:0] f);
        cyc({nm, "_if"}, o, f, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc({nm, "_id"}, o, f, 1'b0, 1'b1, e_id(1'b0));
    endtask

    task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every clocked cycle is an output presentation of this unit
    initial begin
        obs_t  act, exp;
        string nm;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                exp = q_exp.pop_front();
                nm  = q_name.pop_front();
                act = '{state, mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal, sext,
                        shift, alusrca, alusrcb, aluc, pcsrc, illegal, buserr};
                n_chk++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", nm, act, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; op = R; func = 6'b100000; z = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst0", R, 6'b100000, 1'b0, 1'b1, e_rst());
        cyc("rst1", R, 6'b100000, 1'b0, 1'b1, e_rst());
        clrn = 1'b1;

        if_id("add", R, 6'b100000);
        cyc("add_exe", R, 6'b100000, 1'b0, 1'b1, e_alu(3'd2, 2'b00, A_ADD, 1'b0, 1'b0));
        cyc("add_wb",  R, 6'b100000, 1'b0, 1'b1, e_wb(2'b00, A_ADD, 1'b0, 1'b0, 1'b0, 1'b0));

        if_id("sra", R, 6'b000011);
        cyc("sra_exe", R, 6'b000011, 1'b0, 1'b1, e_alu(3'd2, 2'b00, A_SRA, 1'b0, 1'b1));
        cyc("sra_wb",  R, 6'b000011, 1'b0, 1'b1, e_wb(2'b00, A_SRA, 1'b0, 1'b1, 1'b0, 1'b0));

        if_id("lw", 6'b100011, 6'b0);
        cyc("lw_exe", 6'b100011, 6'b0, 1'b0, 1'b1, e_alu(3'd2, 2'b10, A_ADD, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", 6'b100011, 6'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        cyc("lw_mem_rdy", 6'b100011, 6'b0, 1'b0, 1'b1, e_mem(1'b0, 1'b0));
        cyc("lw_wb", 6'b100011, 6'b0, 1'b0, 1'b1, e_wb(2'b10, A_ADD, 1'b1, 1'b0, 1'b1, 1'b1));

        if_id("sw", 6'b101011, 6'b0);
        cyc("sw_exe", 6'b101011, 6'b0, 1'b0, 1'b1, e_alu(3'd2, 2'b10, A_ADD, 1'b1, 1'b0));
        cyc("sw_mem_wait", 6'b101011, 6'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0));
        cyc("sw_mem_rdy",  6'b101011, 6'b0, 1'b0, 1'b1, e_mem(1'b1, 1'b0));

        if_id("beq", 6'b000100, 6'b0);
        cyc("beq_exe_taken", 6'b000100, 6'b0, 1'b1, 1'b1, e_br(1'b1));
        if_id("bne", 6'b000101, 6'b0);
        cyc("bne_exe_not", 6'b000101, 6'b0, 1'b1, 1'b1, e_br(1'b0));

        cyc("j_if",  6'b000010, 6'b0, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc("j_id",  6'b000010, 6'b0, 1'b0, 1'b1, e_jmp(2'b11, 1'b0));
        cyc("jal_if", 6'b000011, 6'b0, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc("jal_id", 6'b000011, 6'b0, 1'b0, 1'b1, e_jmp(2'b11, 1'b1));
        cyc("jr_if", R, 6'b001000, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc("jr_id", R, 6'b001000, 1'b0, 1'b1, e_jmp(2'b10, 1'b0));
        cyc("illop_if", 6'b111111, 6'b0, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc("illop_id", 6'b111111, 6'b0, 1'b0, 1'b1, e_ill());
        cyc("illfn_if", R, 6'b111111, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc("illfn_id", R, 6'b111111, 1'b0, 1'b1, e_ill());

        if_id("ori", 6'b001101, 6'b0);
        cyc("ori_exe", 6'b001101, 6'b0, 1'b0, 1'b1, e_alu(3'd2, 2'b10, A_OR, 1'b0, 1'b0));
        cyc("ori_wb",  6'b001101, 6'b0, 1'b0, 1'b1, e_wb(2'b10, A_OR, 1'b0, 1'b0, 1'b1, 1'b0));
        if_id("lui", 6'b001111, 6'b0);
        cyc("lui_exe", 6'b001111, 6'b0, 1'b0, 1'b1, e_alu(3'd2, 2'b10, A_LUI, 1'b0, 1'b0));
        cyc("lui_wb",  6'b001111, 6'b0, 1'b0, 1'b1, e_wb(2'b10, A_LUI, 1'b0, 1'b0, 1'b1, 1'b0));

        // ready arriving on the fourth stalled cycle is a success, not a timeout
        for (int i = 0; i < 3; i++)
            cyc("addi_if_wait", 6'b001000, 6'b0, 1'b0, 1'b0, e_if(1'b0, 1'b0));
        cyc("addi_if_rdy_edge", 6'b001000, 6'b0, 1'b0, 1'b1, e_if(1'b1, 1'b0));
        cyc("addi_id", 6'b001000, 6'b0, 1'b0, 1'b1, e_id(1'b0));
        cyc("addi_exe", 6'b001000, 6'b0, 1'b0, 1'b1, e_alu(3'd2, 2'b10, A_ADD, 1'b1, 1'b0));
        cyc("addi_wb",  6'b001000, 6'b0, 1'b0, 1'b1, e_wb(2'b10, A_ADD, 1'b1, 1'b0, 1'b1, 1'b0));

        // sw timing out in MEM: strobe drops on the timeout cycle, buserr follows
        if_id("swto", 6'b101011, 6'b0);
        cyc("swto_exe", 6'b101011, 6'b0, 1'b0, 1'b1, e_alu(3'd2, 2'b10, A_ADD, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc("swto_mem_wait", 6'b101011, 6'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0));
        cyc("swto_mem_timeout", 6'b101011, 6'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        cyc("swto_if_buserr", 6'b101011, 6'b0, 1'b0, 1'b0, e_if(1'b0, 1'b1));
        cyc("swto_if_sticky", 6'b101011, 6'b0, 1'b0, 1'b0, e_if(1'b0, 1'b1));

        clrn = 1'b0;
        cyc("rst_mid_clears", 6'b101011, 6'b0, 1'b0, 1'b1, e_rst());
        clrn = 1'b1;

        // fetch timeout: four stalls raise buserr, which then stays set
        for (int i = 0; i < 4; i++)
            cyc("ifto_wait", 6'b001000, 6'b0, 1'b0, 1'b0, e_if(1'b0, 1'b0));
`ifdef MCCU_PERF_EN
        check32("perf_stallcnt", stallcnt, 32'd4);
        check32("perf_instret", instret, 32'd0);
`endif
        cyc("ifto_buserr", 6'b001000, 6'b0, 1'b0, 1'b0, e_if(1'b0, 1'b1));
        cyc("ifto_fetch_sticky", 6'b001000, 6'b0, 1'b0, 1'b1, e_if(1'b1, 1'b1));
        cyc("ifto_id_sticky", 6'b001000, 6'b0, 1'b0, 1'b1, e_id(1'b1));

        for (int i = 0; i < 4 && q_exp.size() > 0; i++)
            @(posedge clk);
        n_chk++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
